// File: rtl/alu_issue_ctrl.sv
// Initiator side of the ALU handshake: issues one decoded op at a time, waits for
// the ALU result (or aborts on timeout) and holds it as a writeback/branch response.
module alu_issue_ctrl #(
    parameter int DATA_W         = 32,
    parameter int OP_W           = 5,
    parameter int RD_W           = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              soc_clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    input  logic [RD_W-1:0]   issue_rd,
    output logic              dat_ready,
    output logic [DATA_W-1:0] ALU_dat1,
    output logic [DATA_W-1:0] ALU_dat2,
    output logic [OP_W-1:0]   Instruction_to_ALU,
    input  logic [DATA_W-1:0] ALU_out,
    input  logic              ALU_overflow,
    input  logic              ALU_zero,
    input  logic              ALU_con_met,
    input  logic              ALU_err,
    input  logic              ALU_ready,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_is_branch,
    output logic              wb_taken,
    output logic              wb_overflow,
    output logic              wb_zero,
    output logic              wb_err,
    output logic              wb_timeout
);
    localparam int               TMR_W         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST      = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [OP_W-1:0]  OP_BRANCH_MAX = OP_W'(5);
    localparam logic [OP_W-1:0]  OP_VALID_MAX  = OP_W'(15);
    localparam logic [OP_W-1:0]  OP_PARKED     = OP_W'(16);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state, state_next;
    logic [TMR_W-1:0]  timer, timer_next;
    logic [RD_W-1:0]   rd_q, rd_next;
    logic              branch_q, branch_next;

    logic              dat_ready_next;
    logic [DATA_W-1:0] dat1_next, dat2_next;
    logic [OP_W-1:0]   instr_next;
    logic              wb_valid_next;
    logic [DATA_W-1:0] wb_data_next;
    logic [RD_W-1:0]   wb_rd_next;
    logic              wb_is_branch_next, wb_taken_next, wb_overflow_next;
    logic              wb_zero_next, wb_err_next, wb_timeout_next;

    assign issue_ready = (state == S_IDLE);

    always_comb begin
        state_next        = state;
        timer_next        = timer;
        rd_next           = rd_q;
        branch_next       = branch_q;
        dat_ready_next    = dat_ready;
        dat1_next         = ALU_dat1;
        dat2_next         = ALU_dat2;
        instr_next        = Instruction_to_ALU;
        wb_valid_next     = wb_valid;
        wb_data_next      = wb_data;
        wb_rd_next        = wb_rd;
        wb_is_branch_next = wb_is_branch;
        wb_taken_next     = wb_taken;
        wb_overflow_next  = wb_overflow;
        wb_zero_next      = wb_zero;
        wb_err_next       = wb_err;
        wb_timeout_next   = wb_timeout;

        case (state)
            S_IDLE: begin
                if (issue_valid) begin
                    if (issue_op <= OP_VALID_MAX) begin
                        dat1_next      = issue_a;
                        dat2_next      = issue_b;
                        instr_next     = issue_op;
                        rd_next        = issue_rd;
                        branch_next    = (issue_op <= OP_BRANCH_MAX);
                        dat_ready_next = 1'b1;
                        timer_next     = '0;
                        state_next     = S_WAIT;
                    end else begin
                        // Rejected opcode: answer directly, the ALU never sees it.
                        wb_valid_next     = 1'b1;
                        wb_err_next       = 1'b1;
                        wb_data_next      = '0;
                        wb_rd_next        = issue_rd;
                        wb_is_branch_next = 1'b0;
                        wb_taken_next     = 1'b0;
                        wb_overflow_next  = 1'b0;
                        wb_zero_next      = 1'b0;
                        wb_timeout_next   = 1'b0;
                        state_next        = S_RESP;
                    end
                end
            end

            S_WAIT: begin
                timer_next = timer + 1'b1;
                // A result arriving on the terminal count still wins over the timeout.
                if (ALU_ready) begin
                    dat_ready_next    = 1'b0;
                    wb_valid_next     = 1'b1;
                    wb_data_next      = ALU_out;
                    wb_rd_next        = rd_q;
                    wb_is_branch_next = branch_q;
                    wb_taken_next     = ALU_con_met & branch_q;
                    wb_overflow_next  = ALU_overflow;
                    wb_zero_next      = ALU_zero;
                    wb_err_next       = ALU_err;
                    wb_timeout_next   = 1'b0;
                    state_next        = S_RESP;
                end else if (timer == TMR_LAST) begin
                    dat_ready_next    = 1'b0;
                    wb_valid_next     = 1'b1;
                    wb_data_next      = '0;
                    wb_rd_next        = rd_q;
                    wb_is_branch_next = branch_q;
                    wb_taken_next     = 1'b0;
                    wb_overflow_next  = 1'b0;
                    wb_zero_next      = 1'b0;
                    wb_err_next       = 1'b1;
                    wb_timeout_next   = 1'b1;
                    state_next        = S_RESP;
                end
            end

            S_RESP: begin
                if (wb_ready) begin
                    wb_valid_next = 1'b0;
                    state_next    = S_IDLE;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            state              <= S_IDLE;
            timer              <= '0;
            rd_q               <= '0;
            branch_q           <= 1'b0;
            dat_ready          <= 1'b0;
            ALU_dat1           <= '0;
            ALU_dat2           <= '0;
            Instruction_to_ALU <= OP_PARKED;
            wb_valid           <= 1'b0;
            wb_data            <= '0;
            wb_rd              <= '0;
            wb_is_branch       <= 1'b0;
            wb_taken           <= 1'b0;
            wb_overflow        <= 1'b0;
            wb_zero            <= 1'b0;
            wb_err             <= 1'b0;
            wb_timeout         <= 1'b0;
        end else begin
            state              <= state_next;
            timer              <= timer_next;
            rd_q               <= rd_next;
            branch_q           <= branch_next;
            dat_ready          <= dat_ready_next;
            ALU_dat1           <= dat1_next;
            ALU_dat2           <= dat2_next;
            Instruction_to_ALU <= instr_next;
            wb_valid           <= wb_valid_next;
            wb_data            <= wb_data_next;
            wb_rd              <= wb_rd_next;
            wb_is_branch       <= wb_is_branch_next;
            wb_taken           <= wb_taken_next;
            wb_overflow        <= wb_overflow_next;
            wb_zero            <= wb_zero_next;
            wb_err             <= wb_err_next;
            wb_timeout         <= wb_timeout_next;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU with programmable latency, directed and
// random ops, and a queue-based scoreboard checked by an independent monitor.
module tb_alu_issue_ctrl;
    localparam int DW = 32;
    localparam int OW = 5;
    localparam int RW = 5;
    localparam int TO = 16;

    logic          soc_clk = 1'b0;
    logic          reset = 1'b1;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic [OW-1:0] issue_op = '0;
    logic [DW-1:0] issue_a = '0;
    logic [DW-1:0] issue_b = '0;
    logic [RW-1:0] issue_rd = '0;
    logic          dat_ready;
    logic [DW-1:0] ALU_dat1, ALU_dat2;
    logic [OW-1:0] Instruction_to_ALU;
    logic [DW-1:0] ALU_out;
    logic          ALU_overflow, ALU_zero, ALU_con_met, ALU_err, ALU_ready;
    logic          wb_valid;
    logic          wb_ready = 1'b1;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_rd;
    logic          wb_is_branch, wb_taken, wb_overflow, wb_zero, wb_err, wb_timeout;

    alu_issue_ctrl #(.DATA_W(DW), .OP_W(OW), .RD_W(RW), .TIMEOUT_CYCLES(TO)) dut (
        .soc_clk(soc_clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
        .dat_ready(dat_ready), .ALU_dat1(ALU_dat1), .ALU_dat2(ALU_dat2),
        .Instruction_to_ALU(Instruction_to_ALU), .ALU_out(ALU_out),
        .ALU_overflow(ALU_overflow), .ALU_zero(ALU_zero), .ALU_con_met(ALU_con_met),
        .ALU_err(ALU_err), .ALU_ready(ALU_ready),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_is_branch(wb_is_branch), .wb_taken(wb_taken), .wb_overflow(wb_overflow),
        .wb_zero(wb_zero), .wb_err(wb_err), .wb_timeout(wb_timeout)
    );

    always #5 soc_clk = ~soc_clk;

    typedef struct packed {
        logic [DW-1:0] r;
        logic          ov;
        logic          z;
        logic          cm;
        logic          er;
    } alu_res_t;

    // Behavioural ALU: 0-5 BEQ/BNE/BLT/BGE/BLTU/BGEU, 6-15 ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU.
    function automatic alu_res_t alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        alu_res_t o;
        o = '0;
        case (op)
            5'd0:  o.cm = (a == b);
            5'd1:  o.cm = (a != b);
            5'd2:  o.cm = ($signed(a) < $signed(b));
            5'd3:  o.cm = ($signed(a) >= $signed(b));
            5'd4:  o.cm = (a < b);
            5'd5:  o.cm = (a >= b);
            5'd6:  begin o.r = a + b; o.ov = (a[31] == b[31]) && (o.r[31] != a[31]); end
            5'd7:  begin o.r = a - b; o.ov = (a[31] != b[31]) && (o.r[31] != a[31]); end
            5'd8:  o.r = a & b;
            5'd9:  o.r = a | b;
            5'd10: o.r = a ^ b;
            5'd11: o.r = a << b[4:0];
            5'd12: o.r = a >> b[4:0];
            5'd13: o.r = $signed(a) >>> b[4:0];
            5'd14: o.r = {31'b0, ($signed(a) < $signed(b))};
            5'd15: o.r = {31'b0, (a < b)};
            default: begin o.r = 32'hDEAD_BEEF; o.er = 1'b1; end
        endcase
        if (op >= 5'd11 && op <= 5'd13 && b[31:5] != '0) begin
            o.er = 1'b1;
            o.r  = '0;
        end
        if (op <= 5'd5) o.z = (a == b);
        else begin
            o.z  = (o.r == '0);
            o.cm = o.r[0];
        end
        return o;
    endfunction

    int       alu_lat = 3;
    logic     noise = 1'b0;
    int       acnt = 0;
    alu_res_t ares;

    always @(posedge soc_clk) acnt <= dat_ready ? acnt + 1 : 0;

    always_comb begin
        ares         = alu_fn(Instruction_to_ALU, ALU_dat1, ALU_dat2);
        ALU_out      = ares.r;
        ALU_overflow = ares.ov;
        ALU_zero     = ares.z;
        ALU_con_met  = ares.cm;
        ALU_err      = ares.er;
        ALU_ready    = dat_ready ? (acnt == alu_lat) : noise;
    end

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic [RW-1:0] rd;
        logic          br, taken, ov, z, err, tmo;
        bit            chk_br, chk_oz;
    } exp_t;

    exp_t          exp_q[$];
    int            cyc = 0;
    int            win_lo = 0, win_hi = 0;
    logic [DW-1:0] m_a = '0, m_b = '0;
    logic [OW-1:0] m_op = 5'd16;
    bit            in_resp = 0;
    logic [43:0]   snap;
    int            checks = 0, failures = 0;
    int            bp_cnt = 0;
    bit            rnd_wb = 0, rnd_noise = 0;

    always @(posedge soc_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: cycle-accurate expectations for handshake outputs plus queue-driven responses.
    always @(negedge soc_clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            in_resp = 0;
            win_lo  = 0;
            win_hi  = 0;
            m_a     = '0;
            m_b     = '0;
            m_op    = 5'd16;
        end else begin
            chk("issue_ready", issue_ready, (exp_q.size() == 0 && !in_resp));
            chk("dat_ready", dat_ready, (cyc >= win_lo && cyc < win_hi));
            chk("alu_ports", {ALU_dat1, ALU_dat2, Instruction_to_ALU}, {m_a, m_b, m_op});
            if (in_resp) begin
                chk("wb_valid_held", wb_valid, 1'b1);
                chk("wb_held_stable", {wb_data, wb_rd, wb_is_branch, wb_taken, wb_overflow,
                                       wb_zero, wb_err, wb_timeout}, snap);
            end else if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("wb_valid_rise", wb_valid, 1'b1);
                chk("wb_data", wb_data, e.data);
                chk("wb_rd", wb_rd, e.rd);
                if (e.chk_br) chk("wb_is_branch", wb_is_branch, e.br);
                chk("wb_taken", wb_taken, e.taken);
                if (e.chk_oz) chk("wb_ovf_zero", {wb_overflow, wb_zero}, {e.ov, e.z});
                chk("wb_err", wb_err, e.err);
                chk("wb_timeout", wb_timeout, e.tmo);
                snap    = {wb_data, wb_rd, wb_is_branch, wb_taken, wb_overflow, wb_zero, wb_err, wb_timeout};
                in_resp = wb_valid;
            end else begin
                chk("wb_valid_quiet", wb_valid, 1'b0);
            end
            if (in_resp && wb_ready) in_resp = 0;
        end
    end

    // Downstream sink and ALU_ready noise while the ALU is not being driven.
    initial begin
        forever begin
            @(posedge soc_clk);
            #2;
            if (bp_cnt > 0) begin
                wb_ready = 1'b0;
                if (wb_valid) bp_cnt--;
            end else begin
                wb_ready = rnd_wb ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            noise = rnd_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Called at a drive point (2 time units after a rising edge); returns at one.
    task automatic issue(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [RW-1:0] rd, input int lat);
        bit       rn, ok;
        int       c0, le;
        exp_t     e;
        alu_res_t r;
        issue_valid = 1'b1;
        issue_op    = op;
        issue_a     = a;
        issue_b     = b;
        issue_rd    = rd;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            rn = issue_ready;
            @(posedge soc_clk);
            #2;
            if (rn) begin
                ok = 1;
                break;
            end
        end
        issue_valid = 1'b0;
        issue_op    = OW'($urandom);
        issue_a     = $urandom;
        issue_b     = $urandom;
        issue_rd    = RW'($urandom);
        chk("issue_accept", ok, 1'b1);
        if (!ok) return;
        c0      = cyc;
        alu_lat = lat;
        e       = '{default: '0};
        e.rd    = rd;
        e.chk_br = 1;
        e.chk_oz = 1;
        if (op > 5'd15) begin
            e.cyc    = c0;
            e.err    = 1'b1;
            e.chk_oz = 0;
        end else begin
            m_a    = a;
            m_b    = b;
            m_op   = op;
            le     = (lat + 1 < TO) ? lat + 1 : TO;
            win_lo = c0;
            win_hi = c0 + le;
            e.cyc  = c0 + le;
            e.br   = (op <= 5'd5);
            if (lat + 1 > TO) begin
                e.err    = 1'b1;
                e.tmo    = 1'b1;
                e.chk_br = 0;
            end else begin
                r       = alu_fn(op, a, b);
                e.data  = r.r;
                e.taken = r.cm && e.br;
                e.ov    = r.ov;
                e.z     = r.z;
                e.err   = r.er;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge soc_clk);
        #2;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    initial begin
        int            sel, lat;
        logic [OW-1:0] op;
        logic [DW-1:0] a, b;
        bit            done;

        idle(3);
        reset = 1'b0;
        chk("reset_wb_outputs", {wb_valid, wb_data, wb_rd, wb_is_branch, wb_taken, wb_overflow,
                                 wb_zero, wb_err, wb_timeout}, '0);
        idle(2);

        issue(5'd6, 32'd5, 32'd3, 5'd1, 3);             // ADD -> 8, 4-cycle latency
        issue(5'd0, 32'd5, 32'd5, 5'd2, 3);             // BEQ taken
        issue(5'd1, 32'd5, 32'd5, 5'd3, 3);             // BNE not taken
        issue(5'd16, 32'd1, 32'd2, 5'd4, 3);            // invalid opcodes
        issue(5'd31, 32'd7, 32'd7, 5'd5, 3);
        issue(5'd6, 32'h7FFF_FFFF, 32'd1, 5'd6, 2);     // signed overflow
        issue(5'd7, 32'd9, 32'd4, 5'd7, 100);           // ALU never answers
        issue(5'd7, 32'd9, 32'd4, 5'd8, TO - 1);        // answer on the terminal count
        issue(5'd8, 32'hF0F0, 32'hFF00, 5'd9, TO);      // one cycle too late
        issue(5'd11, 32'd1, 32'd40, 5'd10, 1);          // ALU-reported error
        issue(5'd2, 32'hFFFF_FFFF, 32'd1, 5'd11, 0);    // BLT signed, immediate ALU

        bp_cnt = 5;
        issue(5'd7, 32'd5, 32'd3, 5'd12, 3);            // SUB under backpressure
        issue(5'd10, 32'hAAAA_5555, 32'h0F0F_0F0F, 5'd13, 3);

        issue(5'd6, 32'd7, 32'd9, 5'd14, 3);            // reset one cycle after issue
        pulse_reset();
        idle(25);

        rnd_wb    = 1;
        rnd_noise = 1;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            op  = (sel == 0) ? OW'($urandom_range(16, 31)) : OW'($urandom_range(0, 15));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if (op >= 5'd11 && op <= 5'd13 && $urandom_range(0, 2) != 0) b = b & 32'h1F;
            lat = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 3, TO + 2) : $urandom_range(0, 4);
            issue(op, a, b, RW'($urandom), lat);
            if ($urandom_range(0, 19) == 0) begin
                pulse_reset();
                idle(3);
            end
        end

        done = 0;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !in_resp) begin
                done = 1;
                break;
            end
            idle(1);
        end
        chk("drain", done, 1'b1);
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the ALU_top handshake. Accepts one decoded ALU/branch op at a time from the decode stage, drives ALU_dat1/ALU_dat2/Instruction_to_ALU/dat_ready, waits for ALU_ready, then captures the result and flags into a held writeback/branch response. Also enforces the inter-op dat_ready low gap, rejects invalid opcodes without touching the ALU, and times out a hung ALU.

Parameters:
DATA_W, 32, operand/result width
OP_W, 5, opcode width; codes 0-5 are branch compares, 6-15 are arithmetic/logic, 16-31 are invalid
RD_W, 5, destination register index width
TIMEOUT_CYCLES, 16, maximum cycles in WAIT before abort (must be >= 2)

Ports:
soc_clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
issue_valid  input  1  upstream op valid
issue_ready  output  1  controller can accept op
issue_op  input  OP_W  opcode
issue_a  input  DATA_W  operand 1
issue_b  input  DATA_W  operand 2
issue_rd  input  RD_W  destination register
dat_ready  output  1  to ALU: operands valid
ALU_dat1  output  DATA_W  to ALU
ALU_dat2  output  DATA_W  to ALU
Instruction_to_ALU  output  OP_W  to ALU
ALU_out  input  DATA_W  from ALU
ALU_overflow  input  1  from ALU
ALU_zero  input  1  from ALU
ALU_con_met  input  1  from ALU
ALU_err  input  1  from ALU
ALU_ready  input  1  from ALU: result valid
wb_valid  output  1  response valid
wb_ready  input  1  downstream accepts response
wb_data  output  DATA_W  captured ALU_out (0 on error)
wb_rd  output  RD_W  echoed issue_rd
wb_is_branch  output  1  op was 0-5
wb_taken  output  1  captured ALU_con_met (branches only, else 0)
wb_overflow  output  1  captured ALU_overflow
wb_zero  output  1  captured ALU_zero
wb_err  output  1  ALU_err, invalid opcode, or timeout
wb_timeout  output  1  error cause was timeout

Behaviour:
- States: IDLE, WAIT, RESP. All outputs are registered except issue_ready, which equals (state==IDLE).
- Reset: state=IDLE, dat_ready=0, ALU_dat1/ALU_dat2=0, Instruction_to_ALU=16, all wb_* outputs=0, timer=0. Reset in any state aborts the op silently; no response is produced.
- IDLE, on issue_valid at the clock edge:
  - op<=15: latch operands, opcode and rd onto the ALU ports; dat_ready<=1; timer<=0; go to WAIT.
  - op>=16: ALU ports and dat_ready are untouched; wb_valid<=1, wb_err<=1, wb_data<=0, wb_is_branch<=0, wb_taken<=0; go to RESP.
- WAIT: ALU port values are held constant and timer increments each cycle.
  - ALU_ready=1 at the edge: capture ALU_out and all flags; wb_err<=ALU_err; wb_taken<=ALU_con_met & is_branch; dat_ready<=0; wb_valid<=1; go to RESP.
  - ALU_ready=0 and timer==TIMEOUT_CYCLES-1: dat_ready<=0; wb_valid<=1; wb_err<=1; wb_timeout<=1; wb_data<=0; all flags 0; go to RESP.
  - If ALU_ready and the timeout terminal count coincide, ALU_ready wins and the response is a normal result.
- RESP: wb_* outputs are held stable while wb_valid=1 and wb_ready=0. On wb_ready=1: wb_valid<=0 and go to IDLE. A new op can be accepted no earlier than the cycle after.
- Gap guarantee: dat_ready is low for at least 2 consecutive cycles between ALU ops (RESP plus IDLE).
- ALU_ready is ignored in IDLE and RESP.
- Latency: with an ALU responding N edges after dat_ready rises, wb_valid rises N+1 edges after the issue handshake. With the current ALU_top (ALU_ready 3 edges after dat_ready), issue-to-wb_valid is 4 cycles.
- Throughput: one op per 6 cycles minimum with the current ALU_top (1 issue edge + 3 ALU edges + 1 RESP + 1 IDLE), given wb_ready held high.

Test Plan:
- ADD: op=6, a=5, b=3, wb_ready=1 -> wb_valid 4 cycles after issue, wb_data=0x8, wb_err=0, wb_is_branch=0; dat_ready low for >=2 cycles afterwards.
- BEQ: op=0, a=b=5 -> wb_is_branch=1, wb_taken=1, wb_data=0; BNE a=b=5 -> wb_taken=0.
- Invalid opcode: op=16 -> dat_ready never rises; wb_valid next cycle with wb_err=1, wb_data=0, wb_timeout=0.
- Timeout: ALU model never raises ALU_ready, TIMEOUT_CYCLES=16 -> wb_valid with wb_err=1, wb_timeout=1, dat_ready=0, 16 cycles after dat_ready rises. Repeat with ALU_ready arriving exactly on the terminal cycle -> normal result, wb_timeout=0.
- Backpressure: SUB a=5, b=3 with wb_ready=0 for 5 cycles -> wb_data=0x2 held stable and issue_ready=0 throughout; a second issue_valid is not accepted until after the wb handshake.
- Reset mid-WAIT: assert reset 1 cycle after issue -> next cycle dat_ready=0, wb_valid=0, issue_ready=1, and no response ever emitted for that op.
